// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, stall encoding,
// field bit positions of the ID->EX bus and the divider state type.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 161;
  localparam int EX_TO_MEM_WD = 81;
  localparam int EX_TO_RF_WD  = 38;
  localparam int STALL_BUS    = 6;
  localparam int DIV_CYCLES   = 32;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // ID->EX bus field positions, MSB to LSB
  localparam int ALU_OP_HI   = 160;
  localparam int ALU_OP_LO   = 149;
  localparam int HILO_OP_HI  = 148;
  localparam int HILO_OP_LO  = 143;
  localparam int MEM_OP_HI   = 142;
  localparam int MEM_OP_LO   = 138;
  localparam int STORE_OP_HI = 137;
  localparam int STORE_OP_LO = 135;
  localparam int PC_HI       = 134;
  localparam int PC_LO       = 103;
  localparam int SRC1_HI     = 102;
  localparam int SRC1_LO     = 71;
  localparam int SRC2_HI     = 70;
  localparam int SRC2_LO     = 39;
  localparam int RTV_HI      = 38;
  localparam int RTV_LO      = 7;
  localparam int SEL_RF_BIT  = 6;
  localparam int RF_WE_BIT   = 5;
  localparam int RF_WADDR_HI = 4;
  localparam int RF_WADDR_LO = 0;

  // one-hot positions inside alu_op / hilo_op / store_op
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam int HL_DIV  = 5;
  localparam int HL_DIVU = 4;
  localparam int HL_MFHI = 3;
  localparam int HL_MFLO = 2;
  localparam int HL_MTHI = 1;
  localparam int HL_MTLO = 0;

  localparam int ST_SB = 2;
  localparam int ST_SH = 1;
  localparam int ST_SW = 0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_stage_div.sv
// Iterative restoring divider, one quotient bit per cycle. Signed operands
// are divided as magnitudes and sign-corrected on the final iteration.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ack,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  div_state_e  r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [63:0] r_sr_p0;
  logic [31:0] r_dvs_p0;
  logic [31:0] r_dvd_p0;
  logic        r_neg_q, r_neg_r, r_dz;

  logic [32:0] w_part;
  logic        w_qbit;
  logic [31:0] w_rem_nxt;
  logic [63:0] w_sr_nxt;
  logic        w_last;

  function automatic logic [31:0] mag(input logic signed [31:0] v, input logic s);
    return (s && v[31]) ? 32'(-v) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? 32'(-v) : v;
  endfunction

  always_comb begin
    w_part    = r_sr_p0[63:31];
    w_qbit    = (w_part >= {1'b0, r_dvs_p0});
    w_rem_nxt = w_qbit ? 32'(w_part - {1'b0, r_dvs_p0}) : w_part[31:0];
    w_sr_nxt  = {w_rem_nxt, r_sr_p0[30:0], w_qbit};
  end

  assign w_last = (r_state == DIV_BUSY) && (r_cnt == 5'(DIV_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: if (start)  w_state_nxt = DIV_BUSY;
      DIV_BUSY: if (w_last) w_state_nxt = DIV_DONE;
      DIV_DONE: if (ack)    w_state_nxt = DIV_IDLE;
      default:              w_state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == DIV_IDLE && start) r_cnt <= '0;
      else if (r_state == DIV_BUSY)     r_cnt <= r_cnt + 5'd1;
    end
  end

  // operand capture / iteration boundary
  always_ff @(posedge clk) begin
    if (r_state == DIV_IDLE && start) begin
      r_sr_p0  <= {32'b0, mag(a, signed_op)};
      r_dvs_p0 <= mag(b, signed_op);
      r_dvd_p0 <= a;
      r_neg_q  <= signed_op && (a[31] ^ b[31]);
      r_neg_r  <= signed_op && a[31];
      r_dz     <= (b == 32'd0);
    end else if (r_state == DIV_BUSY) begin
      r_sr_p0  <= w_sr_nxt;
    end
  end

  // busy means "result not yet available", so it is also high in IDLE
  assign busy = (r_state != DIV_DONE);
  assign done = w_last;
  assign quo  = r_dz ? 32'hFFFF_FFFF : neg_if(w_sr_nxt[31:0], r_neg_q);
  assign rem  = r_dz ? r_dvd_p0      : neg_if(w_sr_nxt[63:32], r_neg_r);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID->EX register, ALU, HI/LO with iterative divider,
// data SRAM request formatting and EX->MEM / forwarding bus packing.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    ex_is_load,
  output logic                    stallreq_for_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  logic [ID_TO_EX_WD-1:0] r_id_ex_p0;
  logic [31:0]            r_hi, r_lo;

  logic [11:0]        w_alu_op;
  logic [5:0]         w_hilo_op;
  logic [4:0]         w_mem_op;
  logic [2:0]         w_store_op;
  logic [31:0]        w_pc, w_src1, w_src2, w_rt_val;
  logic signed [31:0] w_src1_s, w_src2_s;
  logic               w_sel_rf, w_rf_we;
  logic [4:0]         w_rf_waddr, w_sa;
  logic [31:0]        w_sum, w_alu, w_result, w_wdata;
  logic [3:0]         w_wen;
  logic               w_is_div, w_div_busy, w_div_done, w_reload;
  logic [31:0]        w_quo, w_rem;
  logic               w_unused_stall;

  assign w_reload       = (stall[2] == NO_STOP);
  assign w_unused_stall = ^{stall[5:4], stall[1:0]};

  // ID -> EX register boundary
  always_ff @(posedge clk) begin
    if (rst)
      r_id_ex_p0 <= '0;
    else if (stall[2] == STOP && stall[3] == NO_STOP)
      r_id_ex_p0 <= '0;
    else if (w_reload)
      r_id_ex_p0 <= id_to_ex_bus;
  end

  assign w_alu_op   = r_id_ex_p0[ALU_OP_HI:ALU_OP_LO];
  assign w_hilo_op  = r_id_ex_p0[HILO_OP_HI:HILO_OP_LO];
  assign w_mem_op   = r_id_ex_p0[MEM_OP_HI:MEM_OP_LO];
  assign w_store_op = r_id_ex_p0[STORE_OP_HI:STORE_OP_LO];
  assign w_pc       = r_id_ex_p0[PC_HI:PC_LO];
  assign w_src1     = r_id_ex_p0[SRC1_HI:SRC1_LO];
  assign w_src2     = r_id_ex_p0[SRC2_HI:SRC2_LO];
  assign w_rt_val   = r_id_ex_p0[RTV_HI:RTV_LO];
  assign w_sel_rf   = r_id_ex_p0[SEL_RF_BIT];
  assign w_rf_we    = r_id_ex_p0[RF_WE_BIT];
  assign w_rf_waddr = r_id_ex_p0[RF_WADDR_HI:RF_WADDR_LO];
  assign w_src1_s   = w_src1;
  assign w_src2_s   = w_src2;
  assign w_sa       = w_src1[4:0];
  assign w_sum      = w_src1 + w_src2;

  always_comb begin
    w_alu = 32'd0;
    if      (w_alu_op[ALU_ADD])  w_alu = w_sum;
    else if (w_alu_op[ALU_SUB])  w_alu = w_src1 - w_src2;
    else if (w_alu_op[ALU_SLT])  w_alu = {31'd0, (w_src1_s < w_src2_s)};
    else if (w_alu_op[ALU_SLTU]) w_alu = {31'd0, (w_src1 < w_src2)};
    else if (w_alu_op[ALU_AND])  w_alu = w_src1 & w_src2;
    else if (w_alu_op[ALU_NOR])  w_alu = ~(w_src1 | w_src2);
    else if (w_alu_op[ALU_OR])   w_alu = w_src1 | w_src2;
    else if (w_alu_op[ALU_XOR])  w_alu = w_src1 ^ w_src2;
    else if (w_alu_op[ALU_SLL])  w_alu = w_src2 << w_sa;
    else if (w_alu_op[ALU_SRL])  w_alu = w_src2 >> w_sa;
    else if (w_alu_op[ALU_SRA])  w_alu = w_src2_s >>> w_sa;
    else if (w_alu_op[ALU_LUI])  w_alu = {w_src2[15:0], 16'd0};
  end

  always_comb begin
    w_result = w_alu;
    if      (w_hilo_op[HL_MFHI]) w_result = r_hi;
    else if (w_hilo_op[HL_MFLO]) w_result = r_lo;
  end

  // low address bits beyond the access size are ignored, never trapped
  always_comb begin
    w_wen   = 4'd0;
    w_wdata = 32'd0;
    if (w_store_op[ST_SB]) begin
      w_wen   = 4'b0001 << w_sum[1:0];
      w_wdata = {4{w_rt_val[7:0]}};
    end else if (w_store_op[ST_SH]) begin
      w_wen   = w_sum[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{w_rt_val[15:0]}};
    end else if (w_store_op[ST_SW]) begin
      w_wen   = 4'b1111;
      w_wdata = w_rt_val;
    end
  end

  assign w_is_div = w_hilo_op[HL_DIV] | w_hilo_op[HL_DIVU];

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (w_is_div),
    .ack       (w_reload),
    .signed_op (w_hilo_op[HL_DIV]),
    .a         (w_src1),
    .b         (w_src2),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quo       (w_quo),
    .rem       (w_rem)
  );

  // mthi/mtlo rewrite the same value while held, so repeats are harmless
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_div_done) begin
      r_hi <= w_rem;
      r_lo <= w_quo;
    end else begin
      if (w_hilo_op[HL_MTHI]) r_hi <= w_src1;
      if (w_hilo_op[HL_MTLO]) r_lo <= w_src1;
    end
  end

  assign stallreq_for_ex = w_is_div && w_div_busy;
  assign ex_is_load      = |w_mem_op;
  assign data_sram_en    = (|w_mem_op) | (|w_store_op);
  assign data_sram_wen   = w_wen;
  assign data_sram_addr  = w_sum;
  assign data_sram_wdata = w_wdata;

  assign ex_to_mem_bus = {w_mem_op, w_pc, data_sram_en, w_wen,
                          w_sel_rf, w_rf_we, w_rf_waddr, w_result};
  assign ex_to_rf_bus  = {w_rf_we, w_rf_waddr, w_result};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, store formatting, HI/LO moves,
// divider timing/results, reset mid-division and stall handling.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [160:0] id_bus;
  logic [80:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         ex_is_load, stallreq_for_ex, data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  int n_chk = 0;
  int n_err = 0;
  int cyc;

  localparam logic [11:0] A_ADD = 12'h800, A_SUB = 12'h400, A_SLT = 12'h200,
                          A_SLTU = 12'h100, A_AND = 12'h080, A_NOR = 12'h040,
                          A_OR = 12'h020, A_XOR = 12'h010, A_SLL = 12'h008,
                          A_SRL = 12'h004, A_SRA = 12'h002, A_LUI = 12'h001;
  localparam logic [5:0]  H_DIV = 6'h20, H_DIVU = 6'h10, H_MFHI = 6'h08,
                          H_MFLO = 6'h04, H_MTHI = 6'h02, H_MTLO = 6'h01;
  localparam logic [4:0]  M_LW = 5'h01;
  localparam logic [2:0]  S_SB = 3'b100, S_SH = 3'b010, S_SW = 3'b001;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .ex_is_load      (ex_is_load),
    .stallreq_for_ex (stallreq_for_ex),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  function automatic logic [160:0] mk(input logic [11:0] alu, input logic [5:0] hl,
                                      input logic [4:0] mem, input logic [2:0] st,
                                      input logic [31:0] pc, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [31:0] rt,
                                      input logic sel, input logic we, input logic [4:0] wa);
    return {alu, hl, mem, st, pc, s1, s2, rt, sel, we, wa};
  endfunction

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [160:0] b);
    id_bus = b;
    stall  = 6'b000000;
    tick();
  endtask

  // pipeline control stand-in: hold EX and MEM while EX requests a stall
  task automatic run_div(output int n);
    n = 0;
    while (stallreq_for_ex && n < 100) begin
      stall = 6'b001111;
      n++;
      tick();
    end
    stall = 6'b000000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    stall  = 6'b000000;
    id_bus = mk(A_ADD, 6'h0, 5'h0, 3'b0, 32'h400, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 5'd9);
    tick();
    tick();
    check("reset_mem_bus", ex_to_mem_bus, 81'd0);
    check("reset_misc", {ex_to_rf_bus, ex_is_load, stallreq_for_ex, data_sram_en,
                         data_sram_wen, data_sram_addr, data_sram_wdata}, 0);
    rst = 1'b0;

    // add
    issue(mk(A_ADD, 6'h0, 5'h0, 3'b0, 32'h400, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 5'd9));
    check("add_result", ex_to_rf_bus[31:0], 32'd12);
    check("add_rf_bus", ex_to_rf_bus, {1'b1, 5'd9, 32'd12});
    check("add_mem_bus", ex_to_mem_bus,
          {5'd0, 32'h400, 1'b0, 4'd0, 1'b0, 1'b1, 5'd9, 32'd12});
    check("add_stallreq", stallreq_for_ex, 1'b0);

    // stores
    issue(mk(A_ADD, 6'h0, 5'h0, S_SB, 32'h404, 32'h1000, 32'd3, 32'h12345678, 1'b0, 1'b0, 5'd0));
    check("sb_req", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
          {1'b1, 4'b1000, 32'h1003, 32'h78787878});
    check("sb_bus_wen", ex_to_mem_bus[43:39], {1'b1, 4'b1000});
    issue(mk(A_ADD, 6'h0, 5'h0, S_SH, 32'h408, 32'h1000, 32'd2, 32'h12345678, 1'b0, 1'b0, 5'd0));
    check("sh_req", {data_sram_wen, data_sram_wdata}, {4'b1100, 32'h56785678});
    issue(mk(A_ADD, 6'h0, 5'h0, S_SW, 32'h40C, 32'h1000, 32'd4, 32'h12345678, 1'b0, 1'b0, 5'd0));
    check("sw_req", {data_sram_wen, data_sram_addr, data_sram_wdata},
          {4'b1111, 32'h1004, 32'h12345678});

    // load
    issue(mk(A_ADD, 6'h0, M_LW, 3'b0, 32'h410, 32'h2000, 32'd8, 32'hDEAD, 1'b1, 1'b1, 5'd3));
    check("lw_req", {data_sram_en, data_sram_wen, ex_is_load, data_sram_addr},
          {1'b1, 4'b0000, 1'b1, 32'h2008});
    check("lw_mem_bus", ex_to_mem_bus,
          {5'h01, 32'h410, 1'b1, 4'd0, 1'b1, 1'b1, 5'd3, 32'h2008});

    // ALU ops
    issue(mk(A_SUB, 6'h0, 5'h0, 3'b0, 32'h0, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 5'd1));
    check("sub", ex_to_rf_bus[31:0], 32'hFFFFFFFE);
    issue(mk(A_SLT, 6'h0, 5'h0, 3'b0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 1'b1, 5'd1));
    check("slt_signed", ex_to_rf_bus[31:0], 32'd1);
    issue(mk(A_SLTU, 6'h0, 5'h0, 3'b0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 1'b1, 5'd1));
    check("sltu_unsigned", ex_to_rf_bus[31:0], 32'd0);
    issue(mk(A_AND, 6'h0, 5'h0, 3'b0, 32'h0, 32'hF0F000FF, 32'h0FF00F0F, 32'h0, 1'b0, 1'b1, 5'd1));
    check("and", ex_to_rf_bus[31:0], 32'h00F0000F);
    issue(mk(A_OR, 6'h0, 5'h0, 3'b0, 32'h0, 32'hF0F000FF, 32'h0FF00F0F, 32'h0, 1'b0, 1'b1, 5'd1));
    check("or", ex_to_rf_bus[31:0], 32'hFFF00FFF);
    issue(mk(A_XOR, 6'h0, 5'h0, 3'b0, 32'h0, 32'hF0F000FF, 32'h0FF00F0F, 32'h0, 1'b0, 1'b1, 5'd1));
    check("xor", ex_to_rf_bus[31:0], 32'hFF000FF0);
    issue(mk(A_NOR, 6'h0, 5'h0, 3'b0, 32'h0, 32'hF0F000FF, 32'h0FF00F0F, 32'h0, 1'b0, 1'b1, 5'd1));
    check("nor", ex_to_rf_bus[31:0], 32'h000FF000);
    issue(mk(A_SLL, 6'h0, 5'h0, 3'b0, 32'h0, 32'd4, 32'h80000001, 32'h0, 1'b0, 1'b1, 5'd1));
    check("sll", ex_to_rf_bus[31:0], 32'h00000010);
    issue(mk(A_SRL, 6'h0, 5'h0, 3'b0, 32'h0, 32'd4, 32'h80000001, 32'h0, 1'b0, 1'b1, 5'd1));
    check("srl", ex_to_rf_bus[31:0], 32'h08000000);
    issue(mk(A_SRA, 6'h0, 5'h0, 3'b0, 32'h0, 32'd4, 32'h80000001, 32'h0, 1'b0, 1'b1, 5'd1));
    check("sra", ex_to_rf_bus[31:0], 32'hF8000000);
    issue(mk(A_LUI, 6'h0, 5'h0, 3'b0, 32'h0, 32'd0, 32'hABCD1234, 32'h0, 1'b0, 1'b1, 5'd1));
    check("lui", ex_to_rf_bus[31:0], 32'h12340000);

    // HI/LO moves
    issue(mk(12'h0, H_MTHI, 5'h0, 3'b0, 32'h0, 32'hABCD0001, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0));
    issue(mk(12'h0, H_MTLO, 5'h0, 3'b0, 32'h0, 32'h13579BDF, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0));
    issue(mk(12'h0, H_MFHI, 5'h0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd2));
    check("mthi_mfhi", ex_to_rf_bus[31:0], 32'hABCD0001);
    issue(mk(12'h0, H_MFLO, 5'h0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd2));
    check("mtlo_mflo", ex_to_rf_bus[31:0], 32'h13579BDF);

    // signed div -7/2
    issue(mk(12'h0, H_DIV, 5'h0, 3'b0, 32'h500, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0, 1'b0, 5'd0));
    run_div(cyc);
    check("div_stall_cycles", cyc, 33);
    stall = 6'b001111;
    tick();
    check("div_done_hold_stallreq", stallreq_for_ex, 1'b0);
    tick();
    check("div_done_hold_stallreq2", stallreq_for_ex, 1'b0);
    issue(mk(12'h0, H_MFLO, 5'h0, 3'b0, 32'h504, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd4));
    check("div_mflo", ex_to_rf_bus, {1'b1, 5'd4, 32'hFFFFFFFD});
    check("div_mflo_stallreq", stallreq_for_ex, 1'b0);
    issue(mk(12'h0, H_MFHI, 5'h0, 3'b0, 32'h508, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd4));
    check("div_mfhi", ex_to_rf_bus[31:0], 32'hFFFFFFFF);

    // signed div 7/-2 -> q=-3, r=1
    issue(mk(12'h0, H_DIV, 5'h0, 3'b0, 32'h0, 32'd7, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0, 5'd0));
    run_div(cyc);
    issue(mk(12'h0, H_MFLO, 5'h0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd4));
    check("div2_lo", ex_to_rf_bus[31:0], 32'hFFFFFFFD);
    issue(mk(12'h0, H_MFHI, 5'h0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd4));
    check("div2_hi", ex_to_rf_bus[31:0], 32'd1);

    // divu 0xFFFFFFFF/2 must be unsigned
    issue(mk(12'h0, H_DIVU, 5'h0, 3'b0, 32'h0, 32'hFFFFFFFF, 32'd2, 32'h0, 1'b0, 1'b0, 5'd0));
    run_div(cyc);
    issue(mk(12'h0, H_MFLO, 5'h0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd4));
    check("divu_lo", ex_to_rf_bus[31:0], 32'h7FFFFFFF);
    issue(mk(12'h0, H_MFHI, 5'h0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd4));
    check("divu_hi", ex_to_rf_bus[31:0], 32'd1);

    // divide by zero
    issue(mk(12'h0, H_DIVU, 5'h0, 3'b0, 32'h0, 32'hFFFFFFFF, 32'd0, 32'h0, 1'b0, 1'b0, 5'd0));
    run_div(cyc);
    check("divu0_stall_cycles", cyc, 33);
    issue(mk(12'h0, H_MFHI, 5'h0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd4));
    check("divu0_hi", ex_to_rf_bus[31:0], 32'hFFFFFFFF);
    issue(mk(12'h0, H_MFLO, 5'h0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd4));
    check("divu0_lo", ex_to_rf_bus[31:0], 32'hFFFFFFFF);
    issue(mk(12'h0, H_DIV, 5'h0, 3'b0, 32'h0, 32'hFFFFFFF8, 32'd0, 32'h0, 1'b0, 1'b0, 5'd0));
    run_div(cyc);
    issue(mk(12'h0, H_MFHI, 5'h0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd4));
    check("div0_hi_raw", ex_to_rf_bus[31:0], 32'hFFFFFFF8);
    issue(mk(12'h0, H_MFLO, 5'h0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd4));
    check("div0_lo", ex_to_rf_bus[31:0], 32'hFFFFFFFF);

    // reset in BUSY cycle 10
    issue(mk(12'h0, H_MTHI, 5'h0, 3'b0, 32'h0, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0));
    issue(mk(12'h0, H_DIVU, 5'h0, 3'b0, 32'h0, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 5'd0));
    for (int i = 0; i < 10; i++) begin
      stall = 6'b001111;
      tick();
    end
    check("pre_rst_stallreq", stallreq_for_ex, 1'b1);
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    stall = 6'b000000;
    check("rst_stallreq", stallreq_for_ex, 1'b0);
    check("rst_mem_bus", ex_to_mem_bus, 81'd0);
    issue(mk(12'h0, H_MFHI, 5'h0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd4));
    check("rst_hi", ex_to_rf_bus[31:0], 32'd0);
    issue(mk(12'h0, H_MFLO, 5'h0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd4));
    check("rst_lo", ex_to_rf_bus[31:0], 32'd0);
    issue(mk(12'h0, H_DIVU, 5'h0, 3'b0, 32'h0, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 5'd0));
    run_div(cyc);
    check("restart_stall_cycles", cyc, 33);
    issue(mk(12'h0, H_MFLO, 5'h0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd4));
    check("restart_lo", ex_to_rf_bus[31:0], 32'd14);
    issue(mk(12'h0, H_MFHI, 5'h0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd4));
    check("restart_hi", ex_to_rf_bus[31:0], 32'd2);

    // bubble insert, then hold
    id_bus = mk(A_ADD, 6'h0, 5'h0, 3'b0, 32'h600, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 5'd9);
    stall  = 6'b000111;
    tick();
    check("bubble_mem_bus", ex_to_mem_bus, 81'd0);
    issue(mk(A_ADD, 6'h0, 5'h0, 3'b0, 32'h600, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 5'd9));
    id_bus = mk(A_SUB, 6'h0, 5'h0, 3'b0, 32'h604, 32'd1, 32'd1, 32'h0, 1'b0, 1'b1, 5'd10);
    stall  = 6'b001111;
    tick();
    tick();
    check("hold_mem_bus", ex_to_mem_bus,
          {5'd0, 32'h600, 1'b0, 4'd0, 1'b0, 1'b1, 5'd9, 32'd12});
    stall = 6'b000000;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
